// File: rtl/ex_alu_muldiv_if.sv
// EX-stage bus between the pipeline (master) and the ALU/mul-div unit (slave).
// Handshake: valid_in qualifies alu_ctl/operands/shamt; stall is the inverse of
// ready, so an instruction is consumed on a rising edge where valid_in & !stall.
interface ex_alu_muldiv_if;
   logic        valid_in;
   logic [5:0]  alu_ctl;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [4:0]  shamt;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        stall;
   logic        busy;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        dbg_state;

   modport master (
      output valid_in, alu_ctl, operand_a, operand_b, shamt,
      input  result, zero, overflow, stall, busy, hi_out, lo_out, dbg_state
   );

   modport slave (
      input  valid_in, alu_ctl, operand_a, operand_b, shamt,
      output result, zero, overflow, stall, busy, hi_out, lo_out, dbg_state
   );
endinterface

// File: rtl/ex_alu_muldiv.sv
// Execute-stage ALU with an iterative 32-step multiply/divide engine owning HI/LO.
// Dependent HI/LO-class instructions stall while the engine runs.
module ex_alu_muldiv (
   input  logic           clk,
   input  logic           rst_n,
   ex_alu_muldiv_if.slave bus
);

   localparam logic [5:0] OP_SLL  = 6'b000000;
   localparam logic [5:0] OP_SRL  = 6'b000010;
   localparam logic [5:0] OP_SRA  = 6'b000011;
   localparam logic [5:0] OP_LUI  = 6'b000101;
   localparam logic [5:0] OP_MFHI = 6'b010000;
   localparam logic [5:0] OP_MTHI = 6'b010001;
   localparam logic [5:0] OP_MFLO = 6'b010010;
   localparam logic [5:0] OP_MTLO = 6'b010011;
   localparam logic [5:0] OP_ADD  = 6'b100000;
   localparam logic [5:0] OP_ADDU = 6'b100001;
   localparam logic [5:0] OP_SUB  = 6'b100010;
   localparam logic [5:0] OP_SUBU = 6'b100011;
   localparam logic [5:0] OP_AND  = 6'b100100;
   localparam logic [5:0] OP_OR   = 6'b100101;
   localparam logic [5:0] OP_XOR  = 6'b100110;
   localparam logic [5:0] OP_NOR  = 6'b100111;
   localparam logic [5:0] OP_SLT  = 6'b101010;
   localparam logic [5:0] OP_SLTU = 6'b101011;

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [31:0] opb_q, opb_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;
   logic        a_neg_q, a_neg_d;
   logic        divz_q, divz_d;

   logic [5:0]  ctl;
   logic [31:0] a, b;
   logic        busy, hilo_class, is_muldiv, op_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [31:0] sum, diff;
   logic [32:0] mul_sum, rem_sh, rem_sub;
   logic        div_ge;
   logic [31:0] step_hi, step_lo;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;
   logic [31:0] res;

   assign ctl        = bus.alu_ctl;
   assign a          = bus.operand_a;
   assign b          = bus.operand_b;
   assign busy       = (state_q == ST_RUN);
   // 010000-010011 and 011000-011011 share ctl[5:4]=01 with ctl[2]=0
   assign hilo_class = (ctl[5:4] == 2'b01) && !ctl[2];
   assign is_muldiv  = (ctl[5:2] == 4'b0110);
   assign op_signed  = !ctl[0];
   assign a_neg      = op_signed && a[31];
   assign b_neg      = op_signed && b[31];
   assign a_mag      = a_neg ? (32'd0 - a) : a;
   assign b_mag      = b_neg ? (32'd0 - b) : b;

   assign sum  = a + b;
   assign diff = a - b;

   // One engine step: shift-add on {acc_hi,acc_lo} or restoring shift-subtract
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
   assign rem_sh  = {acc_hi_q, acc_lo_q[31]};
   assign div_ge  = (rem_sh >= {1'b0, opb_q});
   assign rem_sub = rem_sh - {1'b0, opb_q};
   assign step_hi = is_div_q ? (div_ge ? rem_sub[31:0] : rem_sh[31:0]) : mul_sum[32:1];
   assign step_lo = is_div_q ? {acc_lo_q[30:0], div_ge} : {mul_sum[0], acc_lo_q[31:1]};

   assign prod_fix = neg_q ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
   assign quot_fix = neg_q ? (32'd0 - step_lo) : step_lo;
   assign rem_fix  = a_neg_q ? (32'd0 - step_hi) : step_hi;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      a_neg_d  = a_neg_q;
      divz_d   = divz_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.valid_in && is_muldiv) begin
               state_d  = ST_RUN;
               cnt_d    = 6'd0;
               acc_hi_d = 32'd0;
               acc_lo_d = a_mag;
               opb_d    = b_mag;
               is_div_d = ctl[1];
               neg_d    = a_neg ^ b_neg;
               a_neg_d  = a_neg;
               divz_d   = (b == 32'd0);
            end
            if (bus.valid_in && ctl == OP_MTHI) hi_d = a;
            if (bus.valid_in && ctl == OP_MTLO) lo_d = a;
         end
         ST_RUN: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = ST_IDLE;
               if (is_div_q) begin
                  // Divide-by-zero: remainder naturally equals operand_a
                  hi_d = rem_fix;
                  lo_d = divz_q ? 32'hFFFF_FFFF : quot_fix;
               end else begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 6'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         opb_q    <= 32'd0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         divz_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         a_neg_q  <= a_neg_d;
         divz_q   <= divz_d;
      end
   end

   always_comb begin
      res = 32'd0;
      case (ctl)
         OP_ADD, OP_ADDU: res = sum;
         OP_SUB, OP_SUBU: res = diff;
         OP_AND:          res = a & b;
         OP_OR:           res = a | b;
         OP_XOR:          res = a ^ b;
         OP_NOR:          res = ~(a | b);
         OP_SLT:          res = {31'd0, ($signed(a) < $signed(b))};
         OP_SLTU:         res = {31'd0, (a < b)};
         OP_SLL:          res = b << bus.shamt;
         OP_SRL:          res = b >> bus.shamt;
         OP_SRA:          res = $signed(b) >>> bus.shamt;
         OP_LUI:          res = {b[15:0], 16'h0000};
         OP_MFHI:         res = hi_q;
         OP_MFLO:         res = lo_q;
         default:         res = 32'd0;
      endcase
   end

   assign bus.result    = res;
   assign bus.zero      = (res == 32'd0);
   assign bus.overflow  = ((ctl == OP_ADD) && (a[31] == b[31]) && (sum[31] != a[31])) ||
                          ((ctl == OP_SUB) && (a[31] != b[31]) && (diff[31] != a[31]));
   assign bus.stall     = bus.valid_in && busy && hilo_class;
   assign bus.busy      = busy;
   assign bus.hi_out    = hi_q;
   assign bus.lo_out    = lo_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Randomised and directed bench for ex_alu_muldiv against an arithmetic reference model.
module tb_ex_alu_muldiv;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   bit   cmp_en = 0;

   ex_alu_muldiv_if bus ();

   ex_alu_muldiv dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   int          m_cnt = 0;
   logic [63:0] m_pend = 64'd0;

   function automatic bit is_hilo(input logic [5:0] c);
      return (c inside {6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27});
   endfunction

   // returns {hi, lo}
   function automatic logic [63:0] muldiv_model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p, qv, rv;
      sa = $signed(a);
      sb = $signed(b);
      case (c)
         6'd24: begin p = sa * sb; return p; end
         6'd25: begin p = {32'd0, a} * {32'd0, b}; return p; end
         6'd26: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb; r = sa % sb; qv = q; rv = r;
            return {rv[31:0], qv[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // returns {overflow, result}
   function automatic logic [32:0] alu_model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] s, input logic [31:0] hi, input logic [31:0] lo);
      longint      lim, x, t;
      logic [63:0] tv;
      logic [31:0] r;
      logic        o;
      lim = 64'sd2147483647;
      r = 32'd0;
      o = 1'b0;
      case (c)
         6'd32: begin r = a + b; x = longint'($signed(a)) + longint'($signed(b)); o = (x > lim) || (x < -lim - 1); end
         6'd33: r = a + b;
         6'd34: begin r = a - b; x = longint'($signed(a)) - longint'($signed(b)); o = (x > lim) || (x < -lim - 1); end
         6'd35: r = a - b;
         6'd36: r = a & b;
         6'd37: r = a | b;
         6'd38: r = a ^ b;
         6'd39: r = ~(a | b);
         6'd42: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
         6'd43: r = (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
         6'd0:  begin tv = {32'd0, b} * (64'd1 << s); r = tv[31:0]; end
         6'd2:  r = b / (32'd1 << s);
         6'd3:  begin t = $signed(b); t = t >>> s; tv = t; r = tv[31:0]; end
         6'd5:  r = b[15:0] * 32'd65536;
         6'd16: r = hi;
         6'd18: r = lo;
         default: r = 32'd0;
      endcase
      return {o, r};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) {m_hi, m_lo} = m_pend;
      end else if (bus.valid_in) begin
         if (bus.alu_ctl == 6'd17) m_hi = bus.operand_a;
         if (bus.alu_ctl == 6'd19) m_lo = bus.operand_a;
         if (bus.alu_ctl inside {6'd24, 6'd25, 6'd26, 6'd27}) begin
            m_pend = muldiv_model(bus.alu_ctl, bus.operand_a, bus.operand_b);
            m_cnt = 32;
         end
      end
   end

   // scoreboard helper
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare process
   always @(negedge clk) begin
      logic [32:0] e;
      logic        m_busy;
      if (cmp_en) begin
         e = alu_model(bus.alu_ctl, bus.operand_a, bus.operand_b, bus.shamt, m_hi, m_lo);
         m_busy = (m_cnt > 0);
         chk("result",   bus.result, e[31:0]);
         chk("zero",     {31'd0, bus.zero}, {31'd0, (e[31:0] == 32'd0)});
         chk("overflow", {31'd0, bus.overflow}, {31'd0, e[32]});
         chk("stall",    {31'd0, bus.stall}, {31'd0, bus.valid_in && m_busy && is_hilo(bus.alu_ctl)});
         chk("busy",     {31'd0, bus.busy}, {31'd0, m_busy});
         chk("state",    {31'd0, bus.dbg_state}, {31'd0, m_busy});
         chk("hi",       bus.hi_out, m_hi);
         chk("lo",       bus.lo_out, m_lo);
      end
   end

   // driver tasks
   task automatic drive(input logic v, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
      bus.valid_in = v; bus.alu_ctl = c; bus.operand_a = a; bus.operand_b = b; bus.shamt = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 100) begin
         tick();
         n++;
      end
      chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 3))
         0: return $urandom_range(0, 20);
         1: return 32'd0 - $urandom_range(1, 20);
         2: case ($urandom_range(0, 3))
               0: return 32'h8000_0000;
               1: return 32'hFFFF_FFFF;
               2: return 32'h7FFF_FFFF;
               default: return 32'd0;
            endcase
         default: return $urandom;
      endcase
   endfunction

   logic [5:0] codes [20] = '{6'd0, 6'd2, 6'd3, 6'd5, 6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25,
                              6'd26, 6'd27, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd39, 6'd42, 6'd43};

   initial begin
      int          n;
      logic [31:0] ra, rb;
      rst_n = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0);
      #12;
      chk("rst_hi", bus.hi_out, 32'd0);
      chk("rst_lo", bus.lo_out, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      tick();

      drive(1'b1, 6'd32, 32'h7FFF_FFFF, 32'd1, 5'd0); #1;
      chk("add_res", bus.result, 32'h8000_0000);
      chk("add_ovf", {31'd0, bus.overflow}, 32'd1);
      drive(1'b1, 6'd33, 32'h7FFF_FFFF, 32'd1, 5'd0); #1;
      chk("addu_ovf", {31'd0, bus.overflow}, 32'd0);
      drive(1'b1, 6'd42, 32'hFFFF_FFFF, 32'd1, 5'd0); #1;
      chk("slt", bus.result, 32'd1);
      drive(1'b1, 6'd43, 32'hFFFF_FFFF, 32'd1, 5'd0); #1;
      chk("sltu", bus.result, 32'd0);
      drive(1'b1, 6'd3, 32'd0, 32'h8000_0000, 5'd4); #1;
      chk("sra", bus.result, 32'hF800_0000);
      drive(1'b1, 6'd5, 32'd0, 32'h0000_1234, 5'd0); #1;
      chk("lui", bus.result, 32'h1234_0000);
      tick();

      // MULT -3*7 followed by dependent MFLO
      drive(1'b1, 6'd24, 32'hFFFF_FFFD, 32'd7, 5'd0);
      tick();
      drive(1'b1, 6'd18, 32'd0, 32'd0, 5'd0);
      n = 0;
      @(negedge clk);
      while (bus.stall && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("mult_stall_cycles", n, 32'd32);
      chk("mflo_after_mult", bus.result, 32'hFFFF_FFEB);
      chk("mult_hi", bus.hi_out, 32'hFFFF_FFFF);
      tick();

      drive(1'b1, 6'd26, 32'hFFFF_FFF9, 32'd2, 5'd0);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0);
      wait_idle();
      chk("div_lo", bus.lo_out, 32'hFFFF_FFFD);
      chk("div_hi", bus.hi_out, 32'hFFFF_FFFF);

      drive(1'b1, 6'd27, 32'd100, 32'd0, 5'd0);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0);
      wait_idle();
      chk("divu0_hi", bus.hi_out, 32'd100);
      chk("divu0_lo", bus.lo_out, 32'hFFFF_FFFF);

      // MULTU with independent logic ops during RUN
      drive(1'b1, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         ra = $urandom; rb = $urandom;
         drive(1'b1, (i % 2 == 0) ? 6'd36 : 6'd37, ra, rb, 5'd0); #1;
         chk("run_nostall", {31'd0, bus.stall}, 32'd0);
         chk("run_logic", bus.result, (i % 2 == 0) ? (ra & rb) : (ra | rb));
         tick();
      end
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0);
      wait_idle();
      chk("multu_hi", bus.hi_out, 32'hFFFF_FFFE);
      chk("multu_lo", bus.lo_out, 32'd1);

      // reset mid-divide
      drive(1'b1, 6'd26, 32'd1000, 32'd3, 5'd0);
      tick();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0);
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_hi", bus.hi_out, 32'd0);
      chk("abort_lo", bus.lo_out, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      drive(1'b1, 6'd17, 32'hA5A5_A5A5, 32'd0, 5'd0);
      tick();
      drive(1'b1, 6'd16, 32'd0, 32'd0, 5'd0); #1;
      chk("mfhi_after_mthi", bus.result, 32'hA5A5_A5A5);
      tick();

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : codes[$urandom_range(0, 19)],
               rnd_op(), rnd_op(), 5'($urandom_range(0, 31)));
         tick();
      end
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0);
      wait_idle();
      tick();
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
